// File: rtl/counter_up_dwn.sv
// counter_up_dwn: free-running WIDTH-bit up/down counter with a synchronous,
// active-high clear on rstn. The count wraps modulo 2^WIDTH in both
// directions. count_out is taken straight from the register, so no input
// reaches it combinationally.
//
// Control: no handshake. rstn and up_dwn are sampled at every rising edge of
// clk. rstn=1 takes priority and loads zero. Otherwise up_dwn=1 adds one and
// up_dwn=0 subtracts one. The result is visible just after that edge.
module counter_up_dwn #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             up_dwn,
   output logic [WIDTH-1:0] count_out
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_next;

   // Next count: natural WIDTH-bit wrap gives the modulo behaviour both ways.
   always_comb begin
      cnt_next = cnt;
      if (up_dwn) begin
         cnt_next = cnt + ONE;
      end else begin
         cnt_next = cnt - ONE;
      end
   end

   // Count register: the clear wins over counting on any edge where it is high.
   always_ff @(posedge clk) begin
      if (rstn) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

   assign count_out = cnt;

endmodule

// File: tb/tb_counter_up_dwn.sv
// tb_counter_up_dwn: directed and randomized stimulus for counter_up_dwn.
// A reference model tracks the expected count with integer arithmetic. A
// compare process checks count_out against that model on every falling edge.
// A set of literal expectations also pins both the DUT and the model.
module tb_counter_up_dwn;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk;
   logic         rstn;
   logic         up_dwn;
   logic [W-1:0] count_out;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   int           model_cnt   = 0;
   bit           model_valid = 0;

   counter_up_dwn #(.WIDTH(W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .up_dwn    (up_dwn),
      .count_out (count_out)
   );

   // Clock and initial input state.
   initial begin
      clk    = 1'b0;
      rstn   = 1'b1;
      up_dwn = 1'b1;
      forever #5 clk = ~clk;
   end

   // Reference model: the count is an integer kept in 0..MOD-1.
   always @(posedge clk) begin
      if (rstn) begin
         model_cnt   = 0;
         model_valid = 1;
      end else if (model_valid) begin
         if (up_dwn) model_cnt = (model_cnt + 1) % MOD;
         else        model_cnt = (model_cnt + MOD - 1) % MOD;
      end
      if (model_valid) exp_q.push_back(W'(model_cnt));
   end

   // Scoreboard compare at the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         checks++;
         if (count_out !== e) begin
            errors++;
            $display("FAIL model_cmp t=%0t count_out=%h expected=%h", $time, count_out, e);
         end
      end
   end

   // Driver: apply inputs, take one rising edge, then settle 1 time unit.
   task automatic step(input logic r, input logic u);
      rstn   = r;
      up_dwn = u;
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n, input logic r, input logic u);
      for (int i = 0; i < n; i++) step(r, u);
   endtask

   task automatic check_lit(input string name, input logic [W-1:0] e);
      checks++;
      if (count_out !== e) begin
         errors++;
         $display("FAIL %s count_out=%h expected=%h", name, count_out, e);
      end
   endtask

   initial begin
      int n;
      int prev_n;

      // Up count and rollover.
      steps(2, 1'b1, 1'b1);
      check_lit("reset_zero", 4'h0);
      steps(1, 1'b0, 1'b1);
      check_lit("up_first", 4'h1);
      steps(14, 1'b0, 1'b1);
      check_lit("up_max", 4'hF);
      steps(1, 1'b0, 1'b1);
      check_lit("up_wrap", 4'h0);

      // Reset in the middle of a count.
      steps(1, 1'b1, 1'b1);
      steps(10, 1'b0, 1'b1);
      check_lit("mid_count", 4'hA);
      steps(1, 1'b1, 1'b1);
      check_lit("mid_reset", 4'h0);
      steps(1, 1'b1, 1'b1);
      check_lit("mid_hold1", 4'h0);
      steps(1, 1'b1, 1'b0);
      check_lit("mid_hold2", 4'h0);

      // Down count and rollover.
      steps(1, 1'b1, 1'b0);
      steps(1, 1'b0, 1'b0);
      check_lit("down_first", 4'hF);
      steps(15, 1'b0, 1'b0);
      check_lit("down_zero", 4'h0);
      steps(1, 1'b0, 1'b0);
      check_lit("down_wrap", 4'hF);

      // Up N then down N returns to zero.
      prev_n = 0;
      for (int k = 0; k < 3; k++) begin
         do n = $urandom_range(15, 1); while (n == prev_n);
         prev_n = n;
         steps(1, 1'b1, 1'b1);
         steps(n, 1'b0, 1'b1);
         check_lit("dyn_up", W'(n));
         steps(n, 1'b0, 1'b0);
         check_lit("dyn_down", 4'h0);
      end

      // Reset priority while the direction toggles.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, i[0]);
         check_lit("rst_priority", 4'h0);
      end

      // Alternate direction every edge starting from 5.
      steps(5, 1'b0, 1'b1);
      check_lit("alt_start", 4'h5);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, ~i[0]);
         check_lit("alt", (i % 2 == 0) ? 4'h6 : 4'h5);
      end

      // Random traffic with occasional resets, checked by the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(15, 0) == 0), 1'(($urandom_range(1, 0))));
      end

      step(1'b0, 1'b1);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain size=%0d expected=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_up_dwn.md
Name: counter_up_dwn

Overview:
- Free-running WIDTH-bit binary up/down counter, single clock domain.
- Direction is selected every cycle by up_dwn. Counting wraps modulo 2^WIDTH in both directions.
- Used as a general-purpose sequencing/timing counter; count_out is a registered output fed straight to downstream logic.

Parameters:
- WIDTH, 4, bit width of the counter and of count_out (modulus 2^WIDTH; default range 0x0..0xF).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  synchronous reset, active-high: rstn=1 at a rising edge clears the counter. The port keeps the codebase name; polarity is high.
- up_dwn  input  1  direction select, sampled every rising edge: 1 = count up, 0 = count down.
- count_out  output  WIDTH  current count, driven directly from the counter register.

Behaviour:
- Single WIDTH-bit register cnt; count_out = cnt, with no combinational path from inputs to count_out.
- Reset:
  - At a rising edge with rstn=1, cnt <= 0 regardless of up_dwn.
  - Reset takes priority over counting.
  - Reset may be asserted at any time, including mid-count; the counter reads 0 from the first edge at which rstn=1 is sampled.
  - The counter holds 0 for every edge while rstn stays high.
- Counting:
  - At a rising edge with rstn=0 and up_dwn=1: cnt <= cnt + 1 mod 2^WIDTH.
  - At a rising edge with rstn=0 and up_dwn=0: cnt <= cnt - 1 mod 2^WIDTH.
- Latency:
  - One clock; count_out changes only just after a rising edge.
  - The first edge with rstn=0 after reset yields 1 (up) or 2^WIDTH-1 (down).
- Wrap-around:
  - Up from 2^WIDTH-1 (0xF) goes to 0 on the next edge; no saturation.
  - Down from 0 goes to 2^WIDTH-1 (0xF) on the next edge.
  - No flags or status outputs.
- Direction change:
  - up_dwn may toggle on any cycle; the new direction applies from the next rising edge onward.
  - No dead cycle and no reset of the count when direction changes.
  - Up N edges then down N edges returns to the starting value.
- Sequence after reset release (WIDTH=4):
  - Up: 1, 2, ..., 0xF, 0x0, 0x1, ... — 0xF after the 15th edge, 0x0 after the 16th.
  - Down: 0xF, 0xE, ..., 0x0, 0xF, ... — 0x0 after the 16th edge, 0xF after the 17th.
- X handling: the counter is undefined until the first reset; the bench must apply reset before checking.
- Fully synchronous; no asynchronous paths and no latches.

Test Plan:
- Up max/rollover: rstn=1 for 2 edges with up_dwn=1, then rstn=0 -> count_out=0x0 during reset, 0xF after 15 edges, 0x0 after the 16th edge.
- Reset mid-count: count up 10 edges (count_out=0xA), then rstn=1 -> count_out=0x0 after the first reset edge and stays 0x0 while rstn is held 2+ edges.
- Down count/rollover: reset, up_dwn=0, release -> count_out=0xF after 1 edge, 0x0 after 16 edges, 0xF after 17 edges.
- Dynamic direction: reset, up_dwn=1, count N random edges (N in 1..15) -> count_out=N; then switch up_dwn=0 for N edges -> count_out=0x0. Repeat 3 times with different N.
- Reset priority: rstn=1 while toggling up_dwn on every edge -> count_out stays 0x0 throughout.
- Alternating direction: starting from 0x5, toggle up_dwn every edge -> count_out alternates 0x6/0x5 (or 0x4/0x5, depending on the first direction), proving one-cycle direction response.
